// File: rtl/lram_writer_if.sv
`timescale 1ns/1ps
// Signal bundle for the line-RAM writer: start/offset control, header byte
// stream, graphics read port, line-RAM write port and status.
// The master modport is the writer block itself; the slave modport is the
// surrounding environment (list source, graphics memory, line RAM).
interface lram_writer_if;
    // control
    logic       START;
    logic [3:0] LINE_OFFSET;
    // display-list header byte stream
    logic       HDR_VALID;
    logic [7:0] HDR_DATA;
    logic       HDR_READY;
    // graphics read port
    logic        MEM_REQ;
    logic [15:0] MEM_ADDR;
    logic        MEM_ACK;
    logic [7:0]  MEM_DATA;
    // line-RAM write port
    logic [7:0] INPUT_ADDR;
    logic       INPUT_W;
    logic [2:0] PALETTE;
    logic       PALETTE_W;
    logic       WM;
    logic       WM_W;
    logic [7:0] PIXELS;
    logic       PIXELS_W;
    // status
    logic       BUSY;
    logic       DONE;

    modport master (
        input  START, LINE_OFFSET,
        input  HDR_VALID, HDR_DATA,
        output HDR_READY,
        output MEM_REQ, MEM_ADDR,
        input  MEM_ACK, MEM_DATA,
        output INPUT_ADDR, INPUT_W, PALETTE, PALETTE_W, WM, WM_W, PIXELS, PIXELS_W,
        output BUSY, DONE
    );

    modport slave (
        output START, LINE_OFFSET,
        output HDR_VALID, HDR_DATA,
        input  HDR_READY,
        input  MEM_REQ, MEM_ADDR,
        output MEM_ACK, MEM_DATA,
        input  INPUT_ADDR, INPUT_W, PALETTE, PALETTE_W, WM, WM_W, PIXELS, PIXELS_W,
        input  BUSY, DONE
    );
endinterface

// File: rtl/lram_writer.sv
`timescale 1ns/1ps
// Line-RAM writer: walks one zone line of a display list. Each entry's
// header is collected byte by byte, the line RAM is pointed at the object
// (position, palette, write mode), then the object's graphics bytes are
// fetched one at a time and pushed into the line RAM. An entry whose second
// byte decodes as end-of-list finishes the line.
// Every output is decoded from the current state only, so the asynchronous
// reset forces all of them to 0 at once.
module lram_writer (
    input  logic          SYSCLK,
    input  logic          RESET,
    lram_writer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_SETUP = 3'd2,
        S_FETCH = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t state_reg, state_next;

    // header byte index, object byte counter, captured graphics byte and
    // the object's graphics base address (latched once per object so the
    // fetch address cannot move if LINE_OFFSET changes mid-object)
    logic [2:0]  idx_reg,  idx_next;
    logic [5:0]  cnt_reg,  cnt_next;
    logic [7:0]  pix_reg,  pix_next;
    logic [15:0] base_reg, base_next;

    // up to five header bytes, indexed by position in the header
    logic [4:0][7:0] hdr_reg;
    logic            hdr_take;

    assign hdr_take = (state_reg == S_HDR) && bus.HDR_VALID;

    // one storage byte per header position; only the byte at the current
    // index captures, and only on an accepted transfer
    for (genvar gi = 0; gi < 5; gi++) begin : g_hdr
        logic [7:0] byte_reg;

        // capture header byte gi when it is the one being transferred
        always_ff @(posedge SYSCLK or posedge RESET) begin
            if (RESET) begin
                byte_reg <= 8'd0;
            end else if (hdr_take && (idx_reg == 3'(gi))) begin
                byte_reg <= bus.HDR_DATA;
            end
        end

        assign hdr_reg[gi] = byte_reg;
    end

    // Header field decode. Byte 1 with a nonzero width field selects the
    // 4-byte form; zero width with bit 6 set selects the 5-byte form whose
    // palette/width live in byte 3. End-of-list never reaches these fields.
    logic       long_hdr;
    logic [7:0] f_pl;
    logic [7:0] f_ph;
    logic [7:0] f_hpos;
    logic [2:0] f_pal;
    logic [4:0] f_w;
    logic       f_wm;
    logic       f_ind;
    logic [5:0] byte_count;
    logic       last_hdr_byte;
    logic       end_of_list;
    logic [5:0] cnt_plus;

    assign long_hdr = (hdr_reg[1][4:0] == 5'd0) && hdr_reg[1][6];
    assign f_pl     = hdr_reg[0];
    assign f_ph     = hdr_reg[2];
    assign f_pal    = long_hdr ? hdr_reg[3][7:5] : hdr_reg[1][7:5];
    assign f_w      = long_hdr ? hdr_reg[3][4:0] : hdr_reg[1][4:0];
    assign f_hpos   = long_hdr ? hdr_reg[4]      : hdr_reg[3];
    assign f_wm     = long_hdr & hdr_reg[1][7];
    assign f_ind    = long_hdr & hdr_reg[1][5];

    // width field counts down from 32; zero means a full 32-byte object
    assign byte_count = (f_w == 5'd0) ? 6'd32 : (6'd32 - {1'b0, f_w});

    // the header length is known once byte 1 is stored, so by index 3 the
    // stored byte decides whether 3 or 4 is the final index
    assign last_hdr_byte = ((idx_reg == 3'd3) && !long_hdr) || (idx_reg == 3'd4);

    // end-of-list is decided on the incoming byte 1 itself
    assign end_of_list = (idx_reg == 3'd1) &&
                         (bus.HDR_DATA[4:0] == 5'd0) && !bus.HDR_DATA[6];

    assign cnt_plus = cnt_reg + 6'd1;

    // state register
    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // datapath registers: header index, byte counter, captured byte, base
    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            idx_reg  <= 3'd0;
            cnt_reg  <= 6'd0;
            pix_reg  <= 8'd0;
            base_reg <= 16'd0;
        end else begin
            idx_reg  <= idx_next;
            cnt_reg  <= cnt_next;
            pix_reg  <= pix_next;
            base_reg <= base_next;
        end
    end

    // next-state and output decode; all strobes default low
    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        cnt_next       = cnt_reg;
        pix_next       = pix_reg;
        base_next      = base_reg;

        bus.HDR_READY  = 1'b0;
        bus.MEM_REQ    = 1'b0;
        bus.MEM_ADDR   = 16'd0;
        bus.INPUT_ADDR = 8'd0;
        bus.INPUT_W    = 1'b0;
        bus.PALETTE    = 3'd0;
        bus.PALETTE_W  = 1'b0;
        bus.WM         = 1'b0;
        bus.WM_W       = 1'b0;
        bus.PIXELS     = 8'd0;
        bus.PIXELS_W   = 1'b0;
        bus.BUSY       = (state_reg != S_IDLE);
        bus.DONE       = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (bus.START) begin
                    state_next = S_HDR;
                    idx_next   = 3'd0;
                end
            end

            S_HDR: begin
                bus.HDR_READY = 1'b1;
                if (bus.HDR_VALID) begin
                    idx_next = idx_reg + 3'd1;
                    if (end_of_list) begin
                        state_next = S_DONE;
                        idx_next   = 3'd0;
                    end else if (last_hdr_byte) begin
                        state_next = S_SETUP;
                        idx_next   = 3'd0;
                    end
                end
            end

            S_SETUP: begin
                bus.INPUT_W    = 1'b1;
                bus.PALETTE_W  = 1'b1;
                bus.WM_W       = 1'b1;
                bus.INPUT_ADDR = f_hpos;
                bus.PALETTE    = f_pal;
                bus.WM         = f_wm;
                base_next      = {f_ph + {4'd0, bus.LINE_OFFSET}, f_pl};
                cnt_next       = 6'd0;
                // indirect objects only position the line RAM; no graphics
                state_next     = f_ind ? S_HDR : S_FETCH;
            end

            S_FETCH: begin
                bus.MEM_REQ  = 1'b1;
                bus.MEM_ADDR = base_reg + {10'd0, cnt_reg};
                if (bus.MEM_ACK) begin
                    pix_next   = bus.MEM_DATA;
                    state_next = S_WRITE;
                end
            end

            S_WRITE: begin
                bus.PIXELS_W = 1'b1;
                bus.PIXELS   = pix_reg;
                cnt_next     = cnt_plus;
                if (cnt_plus == byte_count) begin
                    state_next = S_HDR;
                    idx_next   = 3'd0;
                end else begin
                    state_next = S_FETCH;
                end
            end

            S_DONE: begin
                bus.DONE   = 1'b1;
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lram_writer.sv
`timescale 1ns/1ps
// Bench for lram_writer: directed display lists plus randomized lists, with
// graphics memory returning a fixed function of the address after a
// random or forced latency. Expected line-RAM activity is computed from the
// header byte stream alone and compared transaction by transaction.
module tb_lram_writer;

    logic SYSCLK = 1'b0;
    logic RESET  = 1'b0;

    lram_writer_if bus();

    lram_writer dut (
        .SYSCLK (SYSCLK),
        .RESET  (RESET),
        .bus    (bus)
    );

    always #5 SYSCLK = ~SYSCLK;

    int n_checks = 0;
    int n_errors = 0;

    // stimulus bytes for the current list, expected and observed activity
    logic [7:0]  stim[$];
    logic [11:0] exp_setup[$], got_setup[$];
    logic [15:0] exp_addr[$],  got_addr[$];
    logic [7:0]  exp_pix[$],   got_pix[$];
    int          pix_cyc[$];

    int req_cycles, done_cnt, acc_cnt, strobe_cnt;
    int excl_viol, stab_viol, lat_viol, idle_viol, done_viol;
    int cyc = 0;
    int force_delay = -1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ {a[12:8], a[15:13]} ^ 8'h3C;
    endfunction

    function automatic logic [63:0] all_outs();
        return {20'd0, bus.HDR_READY, bus.MEM_REQ, bus.MEM_ADDR, bus.INPUT_ADDR, bus.INPUT_W,
                bus.PALETTE, bus.PALETTE_W, bus.WM, bus.WM_W, bus.PIXELS, bus.PIXELS_W,
                bus.BUSY, bus.DONE};
    endfunction

    // Reference: parse the header stream entry by entry and list the setup
    // writes, graphics addresses and pixel bytes the line should produce.
    task automatic model_stim(input logic [3:0] off);
        int p;
        int n;
        logic [7:0] pl, b1, b3, ph, hpos;
        logic [2:0] pal;
        logic [4:0] w;
        logic wm, ind;
        logic [15:0] base, a;
        exp_setup.delete(); exp_addr.delete(); exp_pix.delete();
        p = 0;
        while (p + 1 < stim.size()) begin
            pl = stim[p];
            b1 = stim[p+1];
            if (b1[4:0] != 5'd0) begin
                pal = b1[7:5]; w = b1[4:0]; ph = stim[p+2]; hpos = stim[p+3];
                wm = 1'b0; ind = 1'b0; p += 4;
            end else if (b1[6]) begin
                b3 = stim[p+3];
                wm = b1[7]; ind = b1[5]; ph = stim[p+2];
                pal = b3[7:5]; w = b3[4:0]; hpos = stim[p+4]; p += 5;
            end else begin
                break;
            end
            exp_setup.push_back({hpos, pal, wm});
            if (!ind) begin
                n = (w == 5'd0) ? 32 : 32 - int'(w);
                base = {8'(ph + 8'(off)), pl};
                for (int i = 0; i < n; i++) begin
                    a = base + 16'(i);
                    exp_addr.push_back(a);
                    exp_pix.push_back(mem_byte(a));
                end
            end
        end
    endtask

    // graphics memory: answers each request after a latency, and sprinkles
    // stray acknowledges while no request is pending
    initial begin
        int wait_left;
        logic in_req;
        in_req = 1'b0;
        wait_left = 0;
        bus.MEM_ACK = 1'b0;
        bus.MEM_DATA = 8'd0;
        forever begin
            @(negedge SYSCLK);
            if (bus.MEM_REQ) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    wait_left = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
                end
                if (wait_left == 0) begin
                    bus.MEM_ACK = 1'b1;
                    bus.MEM_DATA = mem_byte(bus.MEM_ADDR);
                    in_req = 1'b0;
                end else begin
                    bus.MEM_ACK = 1'b0;
                    bus.MEM_DATA = 8'($urandom);
                    wait_left--;
                end
            end else begin
                in_req = 1'b0;
                bus.MEM_ACK = ($urandom_range(0, 3) == 0);
                bus.MEM_DATA = 8'($urandom);
            end
        end
    end

    // monitor: samples outputs just after the falling edge
    initial begin
        logic prev_req, prev_ack, prev_done, ack_last;
        logic [15:0] prev_addr;
        logic [7:0] ack_data;
        int groups;
        prev_req = 0; prev_ack = 0; prev_done = 0; ack_last = 0;
        prev_addr = 0; ack_data = 0;
        forever begin
            @(negedge SYSCLK);
            #1;
            cyc++;
            if (RESET) begin
                prev_req = 0; prev_ack = 0; prev_done = 0; ack_last = 0;
            end else begin
                groups = int'(bus.INPUT_W | bus.PALETTE_W | bus.WM_W) + int'(bus.PIXELS_W)
                       + int'(bus.MEM_REQ) + int'(bus.HDR_READY);
                if (groups > 1) excl_viol++;
                if (groups > 0) strobe_cnt++;
                if ((bus.DONE || !bus.BUSY) && groups > 0) idle_viol++;
                if (bus.INPUT_W | bus.PALETTE_W | bus.WM_W) begin
                    if (!(bus.INPUT_W && bus.PALETTE_W && bus.WM_W)) excl_viol++;
                    got_setup.push_back({bus.INPUT_ADDR, bus.PALETTE, bus.WM});
                end
                if (ack_last && !(bus.PIXELS_W && bus.PIXELS == ack_data)) lat_viol++;
                if (!ack_last && bus.PIXELS_W) lat_viol++;
                if (bus.PIXELS_W) begin
                    got_pix.push_back(bus.PIXELS);
                    pix_cyc.push_back(cyc);
                end
                ack_last = 0;
                if (bus.MEM_REQ) begin
                    req_cycles++;
                    if (prev_req && !prev_ack && bus.MEM_ADDR != prev_addr) stab_viol++;
                    if (bus.MEM_ACK) begin
                        got_addr.push_back(bus.MEM_ADDR);
                        ack_last = 1;
                        ack_data = bus.MEM_DATA;
                    end
                end
                prev_req = bus.MEM_REQ;
                prev_ack = bus.MEM_ACK;
                prev_addr = bus.MEM_ADDR;
                if (bus.DONE) begin
                    done_cnt++;
                    if (prev_done) done_viol++;
                end
                prev_done = bus.DONE;
                if (bus.HDR_READY && bus.HDR_VALID) acc_cnt++;
            end
        end
    end

    // push the stim bytes through the header handshake with random gaps;
    // START is re-asserted while busy at byte index busy_start (-1: never)
    task automatic feed_stim(input int busy_start);
        int idx = 0;
        int guard = 0;
        while (idx < stim.size() && guard < 4000) begin
            @(negedge SYSCLK);
            guard++;
            bus.START = (idx == busy_start);
            bus.HDR_VALID = ($urandom_range(0, 3) != 0);
            bus.HDR_DATA = stim[idx];
            if (bus.HDR_VALID && bus.HDR_READY) idx++;
        end
        @(negedge SYSCLK);
        bus.START = 1'b0;
        bus.HDR_VALID = 1'b0;
        bus.HDR_DATA = 8'($urandom);
        check_val("feed_bytes", 64'(idx), 64'(stim.size()));
    endtask

    task automatic clear_obs();
        got_setup.delete(); got_addr.delete(); got_pix.delete(); pix_cyc.delete();
        req_cycles = 0; done_cnt = 0; acc_cnt = 0; strobe_cnt = 0;
        excl_viol = 0; stab_viol = 0; lat_viol = 0; idle_viol = 0; done_viol = 0;
    endtask

    task automatic cmp_results(input string name);
        check_val({name, ":setup_n"}, 64'(got_setup.size()), 64'(exp_setup.size()));
        for (int i = 0; i < exp_setup.size() && i < got_setup.size(); i++)
            check_val($sformatf("%s:setup[%0d]", name, i), 64'(got_setup[i]), 64'(exp_setup[i]));
        check_val({name, ":addr_n"}, 64'(got_addr.size()), 64'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++)
            check_val($sformatf("%s:addr[%0d]", name, i), 64'(got_addr[i]), 64'(exp_addr[i]));
        check_val({name, ":pix_n"}, 64'(got_pix.size()), 64'(exp_pix.size()));
        for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++)
            check_val($sformatf("%s:pix[%0d]", name, i), 64'(got_pix[i]), 64'(exp_pix[i]));
        check_val({name, ":done_pulses"}, 64'(done_cnt), 64'd1);
        check_val({name, ":hdr_accepted"}, 64'(acc_cnt), 64'(stim.size()));
        check_val({name, ":exclusive"}, 64'(excl_viol), 64'd0);
        check_val({name, ":addr_stable"}, 64'(stab_viol), 64'd0);
        check_val({name, ":write_after_ack"}, 64'(lat_viol), 64'd0);
        check_val({name, ":quiet_idle_done"}, 64'(idle_viol), 64'd0);
        check_val({name, ":done_width"}, 64'(done_viol), 64'd0);
        check_val({name, ":busy_after"}, 64'(bus.BUSY), 64'd0);
        $display("txn %s: bytes=%0d setups=%0d reads=%0d req_cycles=%0d",
                 name, stim.size(), got_setup.size(), got_addr.size(), req_cycles);
    endtask

    task automatic run_list(input string name, input logic [3:0] off, input int busy_start);
        int g = 0;
        clear_obs();
        model_stim(off);
        bus.LINE_OFFSET = off;
        @(negedge SYSCLK);
        bus.START = 1'b1;
        feed_stim(busy_start);
        while (done_cnt == 0 && g < 600) begin
            @(negedge SYSCLK);
            g++;
        end
        repeat (3) @(negedge SYSCLK);
        cmp_results(name);
    endtask

    task automatic gen_random_list();
        int n;
        stim.delete();
        n = $urandom_range(1, 4);
        for (int e = 0; e < n; e++) begin
            stim.push_back(8'($urandom));
            if ($urandom_range(0, 1) == 0) begin
                stim.push_back({3'($urandom), 5'($urandom_range(1, 31))});
                stim.push_back(8'($urandom));
                stim.push_back(8'($urandom));
            end else begin
                stim.push_back({1'($urandom), 1'b1, 1'($urandom_range(0, 3) == 0), 5'd0});
                stim.push_back(8'($urandom));
                stim.push_back(8'($urandom));
                stim.push_back(8'($urandom));
            end
        end
        stim.push_back(8'($urandom));
        stim.push_back({1'($urandom), 1'b0, 1'($urandom), 5'd0});
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        bus.START = 1'b0;
        bus.LINE_OFFSET = 4'd0;
        bus.HDR_VALID = 1'b0;
        bus.HDR_DATA = 8'd0;

        #2 RESET = 1'b1;
        #1 check_val("reset_outs", all_outs(), 64'd0);
        repeat (3) @(negedge SYSCLK);
        RESET = 1'b0;

        // 4-byte header, line offset 2, immediate acks
        force_delay = 0;
        stim = '{8'h00, 8'hFE, 8'h40, 8'h10, 8'h00, 8'h00};
        run_list("r030", 4'd2, -1);
        if (got_setup.size() >= 1) check_val("r030_setup", 64'(got_setup[0]), 64'({8'h10, 3'd7, 1'b0}));
        if (got_addr.size() >= 2) begin
            check_val("r030_addr0", 64'(got_addr[0]), 64'h4200);
            check_val("r030_addr1", 64'(got_addr[1]), 64'h4201);
        end
        if (pix_cyc.size() >= 2) check_val("r030_pix_gap", 64'(pix_cyc[1] - pix_cyc[0]), 64'd2);
        check_val("r030_req_cycles", 64'(req_cycles), 64'd2);

        // 5-byte header, 32 bytes across a page boundary
        stim = '{8'hF0, 8'hC0, 8'h12, 8'h20, 8'h50, 8'h00, 8'h00};
        run_list("r031", 4'd0, -1);
        if (got_setup.size() >= 1) check_val("r031_setup", 64'(got_setup[0]), 64'({8'h50, 3'd1, 1'b1}));
        if (got_addr.size() == 32) begin
            check_val("r031_first", 64'(got_addr[0]), 64'h12F0);
            check_val("r031_last", 64'(got_addr[31]), 64'h130F);
        end

        // immediate end of list
        stim = '{8'h00, 8'h00};
        run_list("r032", 4'd0, -1);
        check_val("r032_strobes_setup", 64'(got_setup.size()), 64'd0);

        // indirect object followed by a normal 1-byte object
        stim = '{8'h11, 8'hE0, 8'h22, 8'h40, 8'h33, 8'h00, 8'hFF, 8'h50, 8'h20, 8'h00, 8'h00};
        run_list("r033", 4'd0, -1);
        check_val("r033_req_cycles", 64'(req_cycles), 64'd1);

        // slow memory: every ack five cycles late
        force_delay = 5;
        stim = '{8'h10, 8'hFD, 8'h80, 8'h44, 8'h00, 8'h00};
        run_list("r034", 4'd0, -1);
        check_val("r034_req_cycles", 64'(req_cycles), 64'd18);

        // randomized lists, some with START re-pulsed while busy
        force_delay = -1;
        for (int r = 0; r < 8; r++) begin
            gen_random_list();
            run_list($sformatf("rand%0d", r), 4'($urandom), (r % 2 == 0) ? 2 : -1);
        end

        // reset in the middle of a fetch
        force_delay = 5;
        clear_obs();
        stim = '{8'h00, 8'h21, 8'h30, 8'h05};
        bus.LINE_OFFSET = 4'd0;
        @(negedge SYSCLK);
        bus.START = 1'b1;
        feed_stim(-1);
        g = 0;
        while (!bus.MEM_REQ && g < 50) begin
            @(negedge SYSCLK);
            g++;
        end
        check_val("r035_req_seen", 64'(bus.MEM_REQ), 64'd1);
        @(negedge SYSCLK);
        bus.START = 1'b1;
        @(negedge SYSCLK);
        bus.START = 1'b0;
        check_val("r035_busy_before", 64'(bus.BUSY), 64'd1);
        RESET = 1'b1;
        #1 check_val("r035_outs_zero", all_outs(), 64'd0);
        repeat (2) @(negedge SYSCLK);
        RESET = 1'b0;
        strobe_cnt = 0;
        repeat (6) @(negedge SYSCLK);
        check_val("r035_quiet_after", 64'(strobe_cnt), 64'd0);
        check_val("r035_idle_after", 64'(bus.BUSY), 64'd0);
        $display("txn r035_reset: reset during fetch, outputs cleared");

        force_delay = 0;
        stim = '{8'h00, 8'hFE, 8'h40, 8'h10, 8'h00, 8'h00};
        run_list("r035_restart", 4'd2, -1);
        if (got_addr.size() >= 1) check_val("r035_addr0", 64'(got_addr[0]), 64'h4200);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lram_writer.md
LRAM_WRITER -- requirements
Module: lram_writer

Interface
REQ-001 SHALL have ports: SYSCLK  in  1  system clock; all logic on its rising edge.
REQ-002 SHALL have RESET  in  1  asynchronous, active-high reset.
REQ-003 SHALL have START  in  1  one-cycle pulse that begins one zone line; ignored unless in IDLE.
REQ-004 SHALL have LINE_OFFSET  in  4  zone line offset, added to the graphics high address byte.
REQ-005 SHALL have HDR_VALID in 1, HDR_DATA in 8 and HDR_READY out 1: display-list header byte stream; a byte transfers on a cycle with VALID and READY both high.
REQ-006 SHALL have MEM_REQ out 1, MEM_ADDR out 16, MEM_ACK in 1 and MEM_DATA in 8: graphics read port; MEM_DATA is valid in the MEM_ACK cycle.
REQ-007 SHALL have INPUT_ADDR out 8 with INPUT_W out 1, PALETTE out 3 with PALETTE_W out 1, WM out 1 with WM_W out 1, and PIXELS out 8 with PIXELS_W out 1: line-RAM write port; the line RAM advances its cell pointer itself on each PIXELS_W.
REQ-008 SHALL have BUSY out 1 (not IDLE) and DONE out 1 (one-cycle end-of-list pulse).

Function
REQ-009 SHALL implement states IDLE, HDR, SETUP, FETCH, WRITE and DONE.
REQ-010 IDLE: a START pulse SHALL move the block to HDR with the header byte index at 0.
REQ-011 HDR: HDR_READY SHALL be 1 and each accepted byte SHALL be stored at the header byte index, after which the index increments.
REQ-012 Byte 1 decode: if bits 4:0 are nonzero, the header SHALL be 4 bytes: PL, {PAL[2:0],W[4:0]}, PH, HPOS.
REQ-013 Byte 1 decode: if bits 4:0 are 0 and bit 6 is 1, the header SHALL be 5 bytes: PL, {WM,1,IND,00000}, PH, {PAL,W}, HPOS.
REQ-014 Byte 1 decode: if bits 4:0 are 0 and bit 6 is 0, the entry is end-of-list and SHALL go to DONE without accepting further bytes.
REQ-015 A 4-byte header SHALL use WM=0 and IND=0.
REQ-016 Object byte count SHALL be (32 - W) mod 32, with W=0 (5-byte header only) meaning 32.
REQ-017 After the final header byte the block SHALL enter SETUP for exactly one cycle, asserting INPUT_W, PALETTE_W and WM_W together with INPUT_ADDR=HPOS, PALETTE=PAL and WM=WM.
REQ-018 From SETUP, if IND=1 the object SHALL be skipped (no fetch, no PIXELS_W) and the block SHALL return to HDR; otherwise it SHALL go to FETCH with i=0.
REQ-019 FETCH: MEM_REQ SHALL be 1 and MEM_ADDR SHALL equal ({PH+LINE_OFFSET (8-bit wrap), PL} + i) mod 65536, both stable until MEM_ACK.
REQ-020 FETCH: on MEM_ACK, MEM_DATA SHALL be captured and the block SHALL move to WRITE.
REQ-021 WRITE: the block SHALL assert PIXELS_W for exactly one cycle with PIXELS=captured byte, then increment i.
REQ-022 WRITE: if i (after increment) equals the byte count, the block SHALL go to HDR with index 0; otherwise it SHALL go back to FETCH.
REQ-023 Throughput SHALL be one graphics byte per two cycles when MEM_ACK is returned in the first REQ cycle.
REQ-024 DONE: DONE SHALL be 1 for one cycle, then the block SHALL return to IDLE.
REQ-025 All write strobes, MEM_REQ and HDR_READY SHALL be mutually exclusive single-purpose pulses/levels; no strobe SHALL assert in IDLE or DONE.
REQ-026 HDR_VALID while not in HDR SHALL be ignored; MEM_ACK while not in FETCH SHALL be ignored.
REQ-027 START while BUSY SHALL be ignored.

Reset
REQ-028 RESET SHALL immediately force IDLE, clear the header index, byte counter and captured byte, and drive every output to 0.
REQ-029 RESET asserted mid-object SHALL abandon the object with no further strobes; after release the block SHALL wait for START.

Verification
REQ-030 4-byte header 0x00,0xFE,0x40,0x10 with LINE_OFFSET=2 and immediate ACKs -> SETUP asserts INPUT_ADDR=0x10, PALETTE=7, WM=0; MEM_ADDR=0x4200 then 0x4201; two PIXELS_W pulses 2 cycles apart; HDR_READY then returns.
REQ-031 5-byte header 0xF0,0xC0,0x12,0x20,0x50 -> WM=1, PALETTE=1, 32 reads 0x12F0..0x130F, crossing the page boundary correctly.
REQ-032 Byte 1=0x00 after PL -> DONE pulses one cycle, BUSY drops, no line-RAM strobes.
REQ-033 5-byte header with IND=1 (byte1=0xE0) -> SETUP strobes only; zero MEM_REQ cycles; next header accepted.
REQ-034 MEM_ACK delayed 5 cycles -> MEM_ADDR held stable, PIXELS_W fires the cycle after ACK carrying that cycle's MEM_DATA.
REQ-035 RESET pulsed during FETCH -> all outputs 0 at once; a START pulse sent while BUSY is ignored; a START after reset restarts cleanly at header byte 0.
